// File: rtl/vga_timing_pkg.sv
// Shared timing constants (640x480@60), coordinate width and the sync
// flag bundle carried alongside pixel data.
package vga_timing_pkg;

    localparam int CNT_W        = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Flags that must stay aligned with pixel data downstream.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } vga_sync_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter: advances on en, returns to 0 after MAX.
// wrap flags that the current count is MAX (not gated by en).
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = 1,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap  = (count_q == W'(MAX));
    assign count = count_q;

    // Next count: wrap to zero at MAX, otherwise increment.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: coordinates, active flag, sync pulses and
// line/frame start strobes, advancing one position per pix_en.
// Optional frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             primed_q;
    logic             step;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    vga_sync_t        sync_q;
    vga_sync_t        sync_d;
    logic             line_start_q;
    logic             line_start_d;
    logic             frame_start_q;
    logic             frame_start_d;

    // The priming strobe loads the origin without moving the counters.
    assign step = pix_en & primed_q;

    wrap_counter #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_hcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (step),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_vcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (step & h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    // Position the counters will hold after this strobe, and its flags.
    always_comb begin
        h_next = '0;
        v_next = '0;
        if (primed_q) begin
            h_next = h_wrap ? '0 : h_cnt + 1'b1;
            v_next = h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
        end
        sync_d.active = (h_next < H_ACT_END) && (v_next < V_ACT_END);
        sync_d.hsync  = ((h_next >= H_SYNC_LO) && (h_next < H_SYNC_HI)) ? HSYNC_POL : ~HSYNC_POL;
        sync_d.vsync  = ((v_next >= V_SYNC_LO) && (v_next < V_SYNC_HI)) ? VSYNC_POL : ~VSYNC_POL;
        line_start_d  = (h_next == '0);
        frame_start_d = (h_next == '0) && (v_next == '0);
    end

    // Flag registers; they only change on a strobe so they track the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_q      <= 1'b0;
            sync_q.active <= 1'b0;
            sync_q.hsync  <= ~HSYNC_POL;
            sync_q.vsync  <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            primed_q      <= 1'b1;
            sync_q        <= sync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Count completed frames at the bottom-right to origin wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (step && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign hcount      = h_cnt;
    assign vcount      = v_cnt;
    assign active      = sync_q.active;
    assign hsync       = sync_q.hsync;
    assign vsync       = sync_q.vsync;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the display path. It produces pixel coordinates, the active-video flag and the sync pulses, one pixel per pix_en strobe.
- Coordinates feed the pixel/framebuffer fetch pipeline.
- hsync/vsync/active go through the latency delay line (LENGTH = fetch pipeline depth), so sync stays aligned with pixel data at the DAC/HDMI encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync asserted level (0 = active-low)
- VSYNC_POL, 0, vsync asserted level (0 = active-low)
- CNT_W, 12, width of coordinate counters

Ports:
- clk  input  1  system/pixel clock
- rst  input  1  synchronous, active-high reset
- pix_en  input  1  pixel strobe; the raster advances one position per cycle with pix_en=1
- hcount  output  CNT_W  current x position, 0..H_TOTAL-1
- vcount  output  CNT_W  current y position, 0..V_TOTAL-1
- active  output  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
- hsync  output  1  horizontal sync at HSYNC_POL level during the sync region
- vsync  output  1  vertical sync at VSYNC_POL level during the sync region
- line_start  output  1  one-pix_en-cycle pulse at hcount==0
- frame_start  output  1  one-pix_en-cycle pulse at hcount==0 && vcount==0
- frame_cnt  output  16  frames completed (only with the optional feature)

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Sync regions:
  - hsync region: H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
  - vsync region: V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC
  - vsync is a function of vcount only, not aligned to the hsync edge.
- All outputs are registered and mutually aligned. Each output set describes the position (hcount, vcount) in the same cycle.
- Reset (rst=1):
  - hcount=0, vcount=0, active=0, line_start=0, frame_start=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL (both inactive)
  - an internal "primed" flag is cleared
- First pix_en cycle after reset:
  - outputs load position (0,0): active=1, line_start=1, frame_start=1, syncs inactive (porch-free origin)
  - primed is set
  - no increment happens on this strobe
- Each subsequent pix_en cycle:
  - hcount increments.
  - Horizontal wrap: at hcount==H_TOTAL-1, hcount goes to 0 and vcount increments.
  - Frame wrap: at (H_TOTAL-1, V_TOTAL-1), both go to 0.
  - All flags are recomputed for the new position.
- pix_en=0: every output holds its value, including line_start and frame_start. Downstream logic must qualify strobes with pix_en.
- rst has priority over pix_en. rst mid-frame returns to the reset state on the next edge, with syncs deasserted immediately on that edge.
- Constraints: H_TOTAL and V_TOTAL must fit in CNT_W. H_SYNC>=1 and V_SYNC>=1. Zero-length porches are legal.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - the frame_cnt port exists
  - reset value 0
  - increments (mod 2^16) on every wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0)
  - not incremented on the post-reset priming strobe
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - localparams for the 640x480@60 timing set
  - CNT_W
  - a packed struct vga_sync_t {hsync, vsync, active}, so the delay line carries exactly $bits(vga_sync_t)
- Sub-module wrap_counter (parameters MAX, W; ports clk, rst, en, count, wrap), instantiated for the horizontal and vertical counters. The vertical en is the horizontal wrap ANDed with pix_en.

Test Plan:
- Reset, then pix_en held high for 2 full frames (defaults) -> frame_start pulses exactly 420000 cycles apart (800x525); hcount peaks at 799 and vcount at 524.
- Horizontal sync check -> on every line, hsync=0 for exactly hcount 656..751 (96 cycles), 1 otherwise; active=0 for hcount>=640.
- Vertical sync check -> vsync=0 exactly for vcount 490..491 (1600 cycles); active=0 for vcount>=480.
- pix_en toggling 1/0 each cycle -> positions advance every other cycle, outputs stable while pix_en=0, frame period 840000 cycles.
- rst asserted at (hcount=700, vcount=300) for 3 cycles -> next edge gives hcount=vcount=0, hsync=vsync=1, active=0; first pix_en after release gives active=1, frame_start=1.
- With VGA_TIMING_FRAME_CNT_EN and small params (H 4/1/1/1, V 3/1/1/1) -> frame_cnt reads 0,1,2,3 at successive frame_start pulses, wrapping 65535 to 0.
